// File: rtl/float_pkg.sv
// Shared widths, encodings and types for the single-precision reciprocal pipeline.
package float_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int LATENCY = 26;

  localparam logic [FRAC_W-1:0] CANON_NAN = 23'h400000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float32_t;

  typedef enum logic [1:0] {NORMAL, ZERO_RES, INF_RES, NAN_RES} spec_cls_t;

  // Side-band that rides along with the mantissa datapath.
  typedef struct packed {
    logic             sign;
    spec_cls_t        cls;
    logic             pow2;
    logic [EXP_W-1:0] exp;
  } recip_meta_t;
endpackage

// File: rtl/float_recip_step.sv
// One restoring-division step: double the remainder, subtract the divisor if it fits.
module float_recip_step
  import float_pkg::*;
(
  input  logic [FRAC_W:0] rem_in,
  input  logic [FRAC_W:0] div,
  output logic [FRAC_W:0] rem_out,
  output logic            q_bit
);
  logic [FRAC_W+1:0] rem_x2;
  logic [FRAC_W+1:0] diff;
  logic              unused_msb;

  assign rem_x2     = {rem_in, 1'b0};
  assign diff       = rem_x2 - {1'b0, div};
  assign q_bit      = (rem_x2 >= {1'b0, div});
  // The remainder always stays below the divisor, so the top bit is never needed.
  assign rem_out    = q_bit ? diff[FRAC_W:0] : rem_x2[FRAC_W:0];
  assign unused_msb = diff[FRAC_W+1];
endmodule

// File: rtl/float_one_div.sv
// Fully pipelined binary32 reciprocal: unpack, 24 restoring steps, pack (26 register stages).
module float_one_div
  import float_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_input_sign,
  input  logic [EXP_W-1:0]  io_input_exp,
  input  logic [FRAC_W-1:0] io_input_frac,
  output logic              io_output_sign,
  output logic [EXP_W-1:0]  io_output_exp,
  output logic [FRAC_W-1:0] io_output_frac
);
  localparam int STEPS = LATENCY - 2;
  localparam int MW    = FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_POW2 = EXP_W'(2*BIAS);
  localparam logic [EXP_W-1:0] EXP_NORM = EXP_W'(2*BIAS - 1);

  logic        [STEPS:0]           vld_pipe;
  recip_meta_t [STEPS:0]           meta_pipe;
  logic        [STEPS-1:0][MW-1:0] rem_pipe, div_pipe, rem_nx;
  logic        [STEPS:0][MW-1:0]   q_pipe;
  logic        [STEPS-1:0]         q_bit;
  recip_meta_t                     meta_d;
  logic        [EXP_W-1:0]         exp_base;
  float32_t                        res_d, res_q;
  logic                            unused_tail;

  // Stage 1 unpack: classify and settle the exponent up front.
  always_comb begin
    meta_d      = '0;
    meta_d.sign = io_input_sign;
    meta_d.pow2 = (io_input_frac == '0);
    exp_base    = meta_d.pow2 ? EXP_POW2 : EXP_NORM;
    meta_d.exp  = exp_base - io_input_exp;
    if (io_input_exp == '0)
      meta_d.cls = INF_RES;
    else if (io_input_exp == '1)
      meta_d.cls = meta_d.pow2 ? ZERO_RES : NAN_RES;
    else if (io_input_exp >= exp_base)
      meta_d.cls = ZERO_RES;
    else
      meta_d.cls = NORMAL;
  end

  for (genvar j = 0; j < STEPS; j++) begin : g_step
    float_recip_step u_step (
      .rem_in  (rem_pipe[j]),
      .div     (div_pipe[j]),
      .rem_out (rem_nx[j]),
      .q_bit   (q_bit[j])
    );
  end

  // Pack: powers of two have an exact 1.0 mantissa that truncated division can't reach.
  always_comb begin
    res_d = '0;
    if (vld_pipe[STEPS]) begin
      res_d.sign = meta_pipe[STEPS].sign;
      case (meta_pipe[STEPS].cls)
        NORMAL: begin
          res_d.exp  = meta_pipe[STEPS].exp;
          res_d.frac = meta_pipe[STEPS].pow2 ? '0 : q_pipe[STEPS][FRAC_W-1:0];
        end
        INF_RES: res_d.exp = '1;
        NAN_RES: begin
          res_d.sign = 1'b0;
          res_d.exp  = '1;
          res_d.frac = CANON_NAN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe  <= '0;
      meta_pipe <= '0;
      rem_pipe  <= '0;
      div_pipe  <= '0;
      q_pipe    <= '0;
      res_q     <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STEPS-1:0], 1'b1};
      meta_pipe   <= {meta_pipe[STEPS-1:0], meta_d};
      rem_pipe[0] <= MW'(1) << FRAC_W;
      div_pipe[0] <= {1'b1, io_input_frac};
      q_pipe[0]   <= '0;
      for (int j = 0; j < STEPS; j++)
        q_pipe[j+1] <= q_pipe[j] | (MW'(q_bit[j]) << (STEPS-1-j));
      for (int j = 0; j < STEPS-1; j++) begin
        rem_pipe[j+1] <= rem_nx[j];
        div_pipe[j+1] <= div_pipe[j];
      end
      res_q <= res_d;
    end
  end

  assign unused_tail    = ^{q_pipe[STEPS][MW-1], rem_nx[STEPS-1]};
  assign io_output_sign = res_q.sign;
  assign io_output_exp  = res_q.exp;
  assign io_output_frac = res_q.frac;
endmodule

// File: tb/tb_float_one_div.sv
// Streaming check of float_one_div against an arithmetic reciprocal model, one compare per cycle.
module tb_float_one_div;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_input_sign = 1'b0;
  logic [7:0]  io_input_exp = '0;
  logic [22:0] io_input_frac = '0;
  logic        io_output_sign;
  logic [7:0]  io_output_exp;
  logic [22:0] io_output_frac;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  float_one_div dut (
    .clock          (clock),
    .reset          (reset),
    .io_input_sign  (io_input_sign),
    .io_input_exp   (io_input_exp),
    .io_input_frac  (io_input_frac),
    .io_output_sign (io_output_sign),
    .io_output_exp  (io_output_exp),
    .io_output_frac (io_output_frac)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
    end
  endtask

  // 1/x from the rules: truncated quotient floor(2^47 / 1.frac), exponent by plain arithmetic.
  function automatic logic [31:0] ref_recip(input logic [31:0] x);
    logic            s;
    int              e, ex;
    logic [22:0]     f;
    longint unsigned q;
    s = x[31];
    e = int'(x[30:23]);
    f = x[22:0];
    if (e == 0) return {s, 8'hFF, 23'h0};
    if (e == 255) return (f != 0) ? 32'h7FC00000 : {s, 31'h0};
    if (f == 0) begin
      ex = 254 - e;
      if (ex <= 0) return {s, 31'h0};
      return {s, 8'(ex), 23'h0};
    end
    q  = (64'd1 << 47) / {40'd0, 1'b1, f};
    ex = 253 - e;
    if (ex <= 0) return {s, 31'h0};
    return {s, 8'(ex), q[22:0]};
  endfunction

  // One cycle: check what the edge just produced, then drive the next operand.
  task automatic step(input logic [31:0] x, input bit rst, input string tag);
    logic [31:0] got, exp_v;
    string       t;
    @(posedge clock);
    #1;
    got = {io_output_sign, io_output_exp, io_output_frac};
    if (exp_q.size() == 26) begin
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
    end else begin
      exp_v = 32'h0;
      t     = "idle0";
    end
    chk(t, got, exp_v);
    reset = rst;
    {io_input_sign, io_input_exp, io_input_frac} = x;
    if (rst) begin
      exp_q.delete();
      tag_q.delete();
    end else begin
      exp_q.push_back(ref_recip(x));
      tag_q.push_back(tag);
    end
  endtask

  initial begin
    logic [31:0] dir [12];
    logic [31:0] x;
    logic [7:0]  edge_e [6];
    dir = '{32'h40000000, 32'h40400000, 32'hBF000000, 32'h00000000,
            32'hFF800000, 32'h7FC00001, 32'h00000001, 32'h7F000000,
            32'h7F400000, 32'h40000000, 32'h40800000, 32'h40400000};
    edge_e = '{8'd0, 8'd255, 8'd1, 8'd252, 8'd253, 8'd254};

    repeat (3) @(posedge clock);
    step(32'h0, 1'b1, "rst");
    step(32'h0, 1'b1, "rst");

    foreach (dir[i]) step(dir[i], 1'b0, $sformatf("dir%0d", i));
    repeat (4) step(32'h0, 1'b0, "zero");

    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      if ($urandom_range(7) == 0) x[30:23] = edge_e[$urandom_range(5)];
      if ($urandom_range(15) == 0) x[22:0] = '0;
      step(x, 1'b0, $sformatf("rnd%0d", i));
    end
    repeat (30) step(32'h0, 1'b0, "zero");

    // Reset with an operand ten cycles deep: its result must never surface.
    step(32'h40000000, 1'b0, "inflight");
    repeat (9) step(32'h40400000, 1'b0, "inflight");
    step(32'h0, 1'b1, "rst");
    step(32'h0, 1'b1, "rst");
    repeat (20) step(32'h0, 1'b0, "postrst");
    step(32'h40000000, 1'b0, "postrst2");
    repeat (30) step(32'h0, 1'b0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/float_one_div.md
FLOAT_ONE_DIV -- requirements
Module: float_one_div

Interface
REQ-001 Parameters: none; widths fixed at EXP_W=8, FRAC_W=23, BIAS=127, LATENCY=26, taken from the package.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_input_sign  in  1  IEEE-754 binary32 sign of operand x.
REQ-005 io_input_exp  in  8  biased exponent of x.
REQ-006 io_input_frac  in  23  fraction of x, hidden bit excluded.
REQ-007 io_output_sign  out  1  sign of 1/x.
REQ-008 io_output_exp  out  8  biased exponent of 1/x.
REQ-009 io_output_frac  out  23  fraction of 1/x.
REQ-010 Handshake: none (no valid/ready); a new operand is accepted every cycle.

Function
REQ-011 Block computes the reciprocal 1/x, single precision, fully pipelined, throughput 1 per cycle.
REQ-012 Pipeline: exactly 26 register stages.
- Stage 1 captures and unpacks the inputs.
- Stages 2-25 each produce one quotient bit.
- Stage 26 packs the result into the output register.
REQ-013 Latency: operand sampled at edge k is driven on outputs immediately after edge k+25 and is valid for one cycle (read at edge k+26).
REQ-014 Mantissa m = 1.frac, m in [1,2).
- Restoring division of 1.0 by m: R0 = 1.0; each step R = 2R; bit = (R >= m); if bit, R = R - m.
- 24 steps give quotient bits 2^-1 .. 2^-24.
- Each step needs a 25-bit compare/subtract.
REQ-015 Normal path, frac != 0: result exp = 253 - e, mantissa = the 24 quotient bits (leading bit always 1), frac = the lower 23 bits.
REQ-016 Normal path, frac == 0 (power of two): result exp = 254 - e, frac = 0.
REQ-017 Rounding: truncation (round toward zero); no sticky or round bit is kept.
REQ-018 Sign: the output sign equals the input sign in every case except NaN.
REQ-019 Special cases:
- e=0 (zero or denormal; denormal flushed to zero) gives signed infinity (exp=255, frac=0).
- e=255 with frac=0 (infinity) gives signed zero.
- e=255 with frac!=0 (NaN) gives canonical NaN: sign 0, exp 255, frac 0x400000.
REQ-020 Underflow: a computed biased exponent <= 0 gives signed zero (no denormal outputs).
REQ-021 Overflow cannot occur; no saturation logic is required.
REQ-022 The special-case flag and sign travel alongside the data through all 26 stages.
REQ-023 Operand values never stall or bubble the pipeline, including all-zero inputs.

Reset
REQ-024 While reset=1 at an edge, every pipeline register, including its special flags, is cleared to 0.
REQ-025 Outputs read 0/0/0 from the edge after reset is asserted until the first post-reset operand reaches stage 26.
REQ-026 Reset mid-operation discards all in-flight operands; no stale result appears afterwards.

Structure
REQ-027 Shared package float_pkg holds:
- EXP_W, FRAC_W, BIAS, LATENCY.
- CANON_NAN frac constant.
- a packed float32 struct typedef (sign, exp, frac).
- a special-class enum (NORMAL, ZERO_RES, INF_RES, NAN_RES).
REQ-028 One sub-module, float_recip_step, implements one restoring step: inputs remainder, divisor, stage bit; outputs the next remainder and the quotient bit. It is instantiated 24 times by a generate loop.
REQ-029 Total RTL is 120-400 lines; no vendor IP and no multipliers.

Verification
REQ-030 Input 2.0 (0x40000000) -> 0x3F000000 (0.5), observed exactly 26 edges after sampling.
REQ-031 Input 3.0 (0x40400000) -> 0x3EAAAAAA (truncated); input -0.5 (0xBF000000) -> 0xC0000000.
REQ-032 Specials:
- +0 -> 0x7F800000.
- -inf (0xFF800000) -> 0x80000000.
- NaN 0x7FC00001 -> 0x7FC00000.
- denormal 0x00000001 -> 0x7F800000.
REQ-033 Underflow: 0x7F000000 -> 0x00000000; 0x7F400000 -> 0x00000000.
REQ-034 Back-to-back inputs 2.0, 4.0, 3.0 on consecutive cycles, then zeros -> outputs 0x3F000000, 0x3E800000, 0x3EAAAAAA on consecutive cycles, then 0x7F800000.
REQ-035 Reset asserted 10 cycles after an operand enters -> outputs stay 0 and that operand's result never appears.
